// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns load/store controls into a req/ack bus
// transaction with byte-lane alignment, extends load data and stalls for memory latency.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_stall,
    input  logic              i_MEM_ctrl_MemRead,
    input  logic              i_MEM_ctrl_MemWrite,
    input  logic [1:0]        i_MEM_ctrl_Size,
    input  logic              i_MEM_ctrl_Unsigned,
    input  logic [ADDR_W-1:0] i_MEM_data_Addr,
    input  logic [31:0]       i_MEM_data_WData,
    output logic              o_stall,
    output logic              o_bubble,
    output logic              o_misalign,
    output logic [31:0]       o_MEM_data_RData,
    output logic              o_dm_req,
    output logic              o_dm_we,
    output logic [ADDR_W-1:0] o_dm_addr,
    output logic [3:0]        o_dm_be,
    output logic [31:0]       o_dm_wdata,
    input  logic              i_dm_ack,
    input  logic [31:0]       i_dm_rdata
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              access;
    logic              illegal;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   lane_be = 4'b0001 << lane;
            2'b01:   lane_be = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'b00:   lane_wdata = {4{wd[7:0]}};
            2'b01:   lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    // Pulls the addressed lane down to bit 0, then sign- or zero-extends it.
    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                                 input logic uns, input logic [1:0] lane);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {lane, 3'b000};
        b = shifted[7:0];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   extract_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   extract_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: extract_load = word;
        endcase
    endfunction

    always_comb begin
        access  = i_MEM_ctrl_MemRead ^ i_MEM_ctrl_MemWrite;
        illegal = access & ((i_MEM_ctrl_Size == 2'b11) ||
                            (i_MEM_ctrl_Size == 2'b01 && i_MEM_data_Addr[0]) ||
                            (i_MEM_ctrl_Size == 2'b10 && i_MEM_data_Addr[1:0] != 2'b00));
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lane_d  = lane_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (access && !illegal) begin
                    state_d = ST_WAIT;
                    req_d   = 1'b1;
                    we_d    = i_MEM_ctrl_MemWrite;
                    addr_d  = {i_MEM_data_Addr[ADDR_W-1:2], 2'b00};
                    be_d    = lane_be(i_MEM_ctrl_Size, i_MEM_data_Addr[1:0]);
                    wdata_d = lane_wdata(i_MEM_ctrl_Size, i_MEM_data_WData);
                    size_d  = i_MEM_ctrl_Size;
                    uns_d   = i_MEM_ctrl_Unsigned;
                    lane_d  = i_MEM_data_Addr[1:0];
                end
            end
            ST_WAIT: begin
                if (i_dm_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        rdata_d = extract_load(i_dm_rdata, size_q, uns_q, lane_q);
                    end
                end
            end
            ST_DONE: begin
                if (!i_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            lane_q  <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lane_q  <= lane_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_misalign       = illegal;
    assign o_bubble         = illegal && (state_q == ST_IDLE);
    assign o_stall          = ((state_q == ST_IDLE) && access && !illegal) || (state_q == ST_WAIT);
    assign o_dm_req         = req_q;
    assign o_dm_we          = we_q;
    assign o_dm_addr        = addr_q;
    assign o_dm_be          = be_q;
    assign o_dm_wdata       = wdata_q;
    assign o_MEM_data_RData = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected bus fields queued at issue and
// popped when the request appears; load data checked in DONE and the cycle after.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              nrst;
    logic              i_stall;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        mem_size;
    logic              mem_uns;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              o_stall;
    logic              o_bubble;
    logic              o_misalign;
    logic [31:0]       o_rdata;
    logic              o_dm_req;
    logic              o_dm_we;
    logic [ADDR_W-1:0] o_dm_addr;
    logic [3:0]        o_dm_be;
    logic [31:0]       o_dm_wdata;
    logic              i_dm_ack;
    logic [31:0]       i_dm_rdata;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t sb_q[$];

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .i_stall             (i_stall),
        .i_MEM_ctrl_MemRead  (mem_read),
        .i_MEM_ctrl_MemWrite (mem_write),
        .i_MEM_ctrl_Size     (mem_size),
        .i_MEM_ctrl_Unsigned (mem_uns),
        .i_MEM_data_Addr     (mem_addr),
        .i_MEM_data_WData    (mem_wdata),
        .o_stall             (o_stall),
        .o_bubble            (o_bubble),
        .o_misalign          (o_misalign),
        .o_MEM_data_RData    (o_rdata),
        .o_dm_req            (o_dm_req),
        .o_dm_we             (o_dm_we),
        .o_dm_addr           (o_dm_addr),
        .o_dm_be             (o_dm_be),
        .o_dm_wdata          (o_dm_wdata),
        .i_dm_ack            (i_dm_ack),
        .i_dm_rdata          (i_dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_size   = 2'b00;
        mem_uns    = 1'b0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        i_stall    = 1'b0;
        i_dm_ack   = 1'b0;
        i_dm_rdata = 32'd0;
    endtask

    task automatic pop_and_compare(input string tag);
        bus_exp_t e;
        check_val({tag, "_req"}, 32'(o_dm_req), 32'd1);
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_val({tag, "_we"}, 32'(o_dm_we), 32'(e.we));
            check_val({tag, "_addr"}, o_dm_addr, e.addr);
            check_val({tag, "_be"}, 32'(o_dm_be), 32'(e.be));
            check_val({tag, "_wdata"}, o_dm_wdata, e.wdata);
        end
    endtask

    // Called one step after a rising edge with the unit in IDLE; returns the same way.
    task automatic run_access(input string tag, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                              input int nwait, input logic [31:0] rd, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                              input int hold);
        bus_exp_t e;
        int stalls;
        logic [31:0] held_addr;
        stalls    = 0;
        mem_read  = !wr;
        mem_write = wr;
        mem_size  = sz;
        mem_uns   = uns;
        mem_addr  = addr;
        mem_wdata = wd;
        e.we    = wr;
        e.addr  = {addr[31:2], 2'b00};
        e.be    = exp_be;
        e.wdata = exp_wdata;
        sb_q.push_back(e);
        #1;
        if (o_stall) stalls++;
        check_val({tag, "_issue_req"}, 32'(o_dm_req), 32'd0);
        tick();
        pop_and_compare(tag);
        held_addr = o_dm_addr;
        for (int k = 1; k <= nwait; k++) begin
            if (k > 1) begin
                tick();
                check_val({tag, "_hold_addr"}, o_dm_addr, held_addr);
            end
            if (o_stall) stalls++;
            if (k == nwait) begin
                i_dm_ack   = 1'b1;
                i_dm_rdata = rd;
                i_stall    = (hold > 0);
            end
        end
        tick();
        i_dm_ack   = 1'b0;
        i_dm_rdata = 32'hA5A5_0F0F;
        check_val({tag, "_stall_cycles"}, 32'(stalls), 32'(nwait + 1));
        check_val({tag, "_done_stall"}, 32'(o_stall), 32'd0);
        check_val({tag, "_done_req"}, 32'(o_dm_req), 32'd0);
        check_val({tag, "_done_rdata"}, o_rdata, exp_rdata);
        for (int h = 0; h < hold; h++) begin
            tick();
            check_val({tag, "_hold_stall"}, 32'(o_stall), 32'd0);
            check_val({tag, "_hold_req"}, 32'(o_dm_req), 32'd0);
            check_val({tag, "_hold_rdata"}, o_rdata, exp_rdata);
        end
        i_stall   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tick();
        check_val({tag, "_wb_rdata"}, o_rdata, exp_rdata);
        check_val({tag, "_wb_req"}, 32'(o_dm_req), 32'd0);
    endtask

    task automatic run_illegal(input string tag, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic [31:0] addr,
                               input logic exp_mis);
        mem_read  = rd;
        mem_write = wr;
        mem_size  = sz;
        mem_addr  = addr;
        #1;
        check_val({tag, "_misalign"}, 32'(o_misalign), 32'(exp_mis));
        check_val({tag, "_bubble"}, 32'(o_bubble), 32'(exp_mis));
        check_val({tag, "_stall"}, 32'(o_stall), 32'd0);
        tick();
        check_val({tag, "_no_req"}, 32'(o_dm_req), 32'd0);
        check_val({tag, "_stall2"}, 32'(o_stall), 32'd0);
        idle_inputs();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        nrst = 1'b0;
        #12;
        check_val("rst_req", 32'(o_dm_req), 32'd0);
        check_val("rst_we", 32'(o_dm_we), 32'd0);
        check_val("rst_addr", o_dm_addr, 32'd0);
        check_val("rst_be", 32'(o_dm_be), 32'd0);
        check_val("rst_wdata", o_dm_wdata, 32'd0);
        check_val("rst_rdata", o_rdata, 32'd0);
        check_val("rst_stall", 32'(o_stall), 32'd0);
        nrst = 1'b1;
        tick();

        run_access("ld_word", 1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 3, 32'h8899_AABB,
                   4'b1111, 32'd0, 32'h8899_AABB, 0);
        run_access("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h203, 32'd0, 1, 32'h8011_2233,
                   4'b1000, 32'd0, 32'hFFFF_FF80, 0);
        run_access("ld_byte_u", 1'b0, 2'b00, 1'b1, 32'h203, 32'd0, 1, 32'h8011_2233,
                   4'b1000, 32'd0, 32'h0000_0080, 0);
        run_access("ld_byte1_u", 1'b0, 2'b00, 1'b1, 32'h201, 32'd0, 2, 32'h8011_2233,
                   4'b0010, 32'd0, 32'h0000_0022, 0);
        run_access("ld_half_hi_s", 1'b0, 2'b01, 1'b0, 32'h202, 32'd0, 1, 32'h8011_2233,
                   4'b1100, 32'd0, 32'hFFFF_8011, 0);
        run_access("ld_half_lo_u", 1'b0, 2'b01, 1'b1, 32'h200, 32'd0, 1, 32'h1234_F00D,
                   4'b0011, 32'd0, 32'h0000_F00D, 0);
        run_access("ld_half_lo_s", 1'b0, 2'b01, 1'b0, 32'h200, 32'd0, 1, 32'h1234_F00D,
                   4'b0011, 32'd0, 32'hFFFF_F00D, 0);

        run_access("st_half", 1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_BEEF, 2, 32'h1111_1111,
                   4'b1100, 32'hBEEF_BEEF, 32'hFFFF_F00D, 0);
        run_access("st_byte", 1'b1, 2'b00, 1'b0, 32'h41, 32'h1234_565A, 1, 32'h2222_2222,
                   4'b0010, 32'h5A5A_5A5A, 32'hFFFF_F00D, 0);
        run_access("st_word", 1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D, 1, 32'h3333_3333,
                   4'b1111, 32'hCAFE_F00D, 32'hFFFF_F00D, 0);

        run_illegal("ill_word", 1'b1, 1'b0, 2'b10, 32'h2, 1'b1);
        run_illegal("ill_size3", 1'b1, 1'b0, 2'b11, 32'h0, 1'b1);
        run_illegal("ill_half", 1'b0, 1'b1, 2'b01, 32'h41, 1'b1);
        run_illegal("rd_and_wr", 1'b1, 1'b1, 2'b10, 32'h0, 1'b0);

        // An ack with no transaction outstanding must not disturb the load data.
        i_dm_ack   = 1'b1;
        i_dm_rdata = 32'h7777_7777;
        tick();
        idle_inputs();
        check_val("stray_ack_rdata", o_rdata, 32'hFFFF_F00D);
        check_val("stray_ack_req", 32'(o_dm_req), 32'd0);

        // Reset in the middle of a transaction, followed by a stale ack.
        mem_read = 1'b1;
        mem_size = 2'b10;
        mem_addr = 32'h400;
        sb_q.push_back('{we: 1'b0, addr: 32'h400, be: 4'b1111, wdata: 32'd0});
        tick();
        pop_and_compare("rst_mid");
        #2;
        nrst = 1'b0;
        #1;
        check_val("rst_mid_req", 32'(o_dm_req), 32'd0);
        check_val("rst_mid_rdata", o_rdata, 32'd0);
        idle_inputs();
        @(negedge clk);
        nrst = 1'b1;
        tick();
        i_dm_ack   = 1'b1;
        i_dm_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        check_val("stale_ack_rdata", o_rdata, 32'd0);
        check_val("stale_ack_req", 32'(o_dm_req), 32'd0);
        check_val("stale_ack_stall", 32'(o_stall), 32'd0);
        tick();

        run_access("ld_istall", 1'b0, 2'b10, 1'b0, 32'h300, 32'd0, 1, 32'h55AA_55AA,
                   4'b1111, 32'd0, 32'h55AA_55AA, 2);
        run_access("ld_after", 1'b0, 2'b00, 1'b1, 32'h302, 32'd0, 1, 32'h00C3_0000,
                   4'b0100, 32'd0, 32'h0000_00C3, 0);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
